dff_pipe: RTL
=============

Name: dff_pipe

Overview:
- Parametrised successor to the single-bit complementary D flip-flop.
- A WIDTH-bit, DEPTH-stage register pipeline. Every stage holds a true/complement pair and a valid bit.
- Adds clock enable (stall), flush, and an occupancy count.
- Used as a generic delay/retiming line wherever data must be delayed a fixed number of cycles with the complementary-output guarantee preserved.

Parameters:
- WIDTH, 8: data width in bits (>=1).
- DEPTH, 4: number of register stages = latency in enabled cycles (>=1).
- RST_VAL, '0 (WIDTH bits): value loaded into every true stage on reset. The complement stages load ~RST_VAL.

Ports:
- clk  input  1  rising-edge clock; only clock.
- rstn  input  1  synchronous, active-low reset.
- en  input  1  shift enable; 0 = hold all stages.
- flush  input  1  clear all valid bits.
- d  input  WIDTH  data into stage 0.
- d_valid  input  1  qualifies d.
- y  output  WIDTH  true output of last stage (DEPTH-1).
- ybar  output  WIDTH  complement output of last stage.
- y_valid  output  1  valid bit of last stage.
- count  output  $clog2(DEPTH+1)  number of valid stages currently held.

Behaviour:
- All state updates on posedge clk only. No asynchronous paths; outputs come directly from last-stage flops (no combinational path from inputs).
- Priority per edge: rstn==0 > flush > en > hold.
- Reset (rstn==0 at edge):
  - every q[i]=RST_VAL, qbar[i]=~RST_VAL, v[i]=0.
  - count=0.
  - Outputs after the edge: y=RST_VAL, ybar=~RST_VAL, y_valid=0, count=0.
  - Reset overrides en/flush/d; reset mid-stream discards all in-flight data.
- Flush (rstn==1, flush==1):
  - all v[i]=0, count=0.
  - q/qbar data held unchanged (not shifted), regardless of en.
  - d/d_valid presented that cycle are dropped.
- Shift (rstn==1, flush==0, en==1):
  - q[0]<=d, qbar[0]<=~d, v[0]<=d_valid.
  - q[i]<=q[i-1], qbar[i]<=qbar[i-1], v[i]<=v[i-1] for i=1..DEPTH-1.
  - Data bubbles (d_valid=0) shift like data; their q contents still shift.
- Hold (en==0): all stages, valid bits and count unchanged.
- Latency: a word accepted at an enabled edge appears on y with y_valid=1 after exactly DEPTH enabled edges. Disabled cycles stretch latency but never drop or duplicate data.
- count:
  - Registered; always equals popcount(v) after each edge.
  - On shift: count_next = count + d_valid - v[DEPTH-1]. Increment and decrement in the same cycle leave count unchanged.
  - Range 0..DEPTH; never wraps. Full pipe of valid words with d_valid=1 keeps count=DEPTH.
- DEPTH==1: single stage; y follows d one enabled edge later; count is 1 bit.
- Invariant at all times after the first edge: qbar[i]==~q[i] for every stage. ybar==~y.
- No X on any output after the first reset edge.

Optional Feature:
- Macro: DFF_PIPE_ASSERT_EN.
- Defined: immediate assertions in an always @(posedge clk) block, evaluated only when rstn==1:
  - per stage, q[i]==~qbar[i];
  - count==popcount(v);
  - count<=DEPTH.
  - On failure: $error with the check name, stage index and $time.
  - No pass messages.
  - One extra check at the edge following a reset edge: y==RST_VAL && y_valid==0.
- Not defined: no assertion code elaborated; functional behaviour identical.

Test Plan:
- WIDTH=8, DEPTH=4, RST_VAL=8'h00. Hold rstn=0 for 2 edges -> y=8'h00, ybar=8'hFF, y_valid=0, count=0.
- en=1; drive d=8'hA5,8'h3C,8'hFF,8'h01 with d_valid=1 on 4 consecutive edges -> count reaches 4. 8'hA5 appears on y with ybar=8'h5A and y_valid=1 after the 4th edge. Following edges output 3C, FF, 01.
- Stall: send 8'h11 then drop en for 3 cycles, then en=1 -> 8'h11 appears after 4 enabled edges (7 total). y and count frozen during the stall.
- Stream valid words into a full pipe (count=4) with d_valid=1 -> count stays 4. Then d_valid=0 for 4 edges -> count decrements 3,2,1,0.
- With count=3: assert flush and en together for one edge -> count=0, y_valid=0, y data unchanged. Then assert rstn=0 mid-stream -> y=RST_VAL next edge.
- DEPTH=1, RST_VAL=8'hC3: reset -> y=8'hC3, ybar=8'h3C. d=8'h7E, en=1 -> y=8'h7E one edge later. With DFF_PIPE_ASSERT_EN defined, no assertion fires across all scenarios.

Source files
------------

// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage delay line of true/complement register pairs with valid bits,
// stall, flush and occupancy count. Define DFF_PIPE_ASSERT_EN to elaborate the built-in checks.
module dff_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       en,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           d,
  input  logic                       d_valid,
  output logic [WIDTH-1:0]           y,
  output logic [WIDTH-1:0]           ybar,
  output logic                       y_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] q_r;
  logic [DEPTH-1:0][WIDTH-1:0] qbar_r;
  logic [DEPTH-1:0]            v_r;
  logic [CW-1:0]               count_r;
  logic [CW-1:0]               count_nxt_s;

  // A word entering and a word leaving in the same shift cancel out.
  always_comb begin
    count_nxt_s = count_r + CW'(d_valid) - CW'(v_r[DEPTH-1]);
  end

  // Pipeline state: reset > flush > shift > hold; flush drops valids but keeps data in place.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_r[i]    <= RST_VAL;
        qbar_r[i] <= ~RST_VAL;
      end
      v_r     <= '0;
      count_r <= '0;
    end else if (flush) begin
      v_r     <= '0;
      count_r <= '0;
    end else if (en) begin
      q_r[0]    <= d;
      qbar_r[0] <= ~d;
      v_r[0]    <= d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        q_r[i]    <= q_r[i-1];
        qbar_r[i] <= qbar_r[i-1];
        v_r[i]    <= v_r[i-1];
      end
      count_r <= count_nxt_s;
    end else begin
      count_r <= count_r;
    end
  end

  assign y       = q_r[DEPTH-1];
  assign ybar    = qbar_r[DEPTH-1];
  assign y_valid = v_r[DEPTH-1];
  assign count   = count_r;

`ifdef DFF_PIPE_ASSERT_EN
  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] x);
    logic [CW-1:0] sum;
    sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sum = sum + CW'(x[i]);
    end
    return sum;
  endfunction

  logic after_rst_r;

  // Structural invariants, checked only while out of reset.
  always @(posedge clk) begin
    after_rst_r <= !rstn;
    if (rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        assert (q_r[i] == ~qbar_r[i])
          else $error("complement_check stage %0d failed at %0t", i, $time);
      end
      assert (count_r == popcount(v_r))
        else $error("count_popcount_check stage %0d failed at %0t", DEPTH - 1, $time);
      assert (count_r <= CW'(DEPTH))
        else $error("count_range_check stage %0d failed at %0t", DEPTH - 1, $time);
      if (after_rst_r) begin
        assert (y == RST_VAL && !y_valid)
          else $error("post_reset_check stage %0d failed at %0t", DEPTH - 1, $time);
      end
    end
  end
`endif

endmodule
